// File: rtl/lcd_text_driver_if.sv
// Pin and text-source bundle for lcd_text_driver: the LCD parallel bus plus the
// index/char_in lookup into the character generator and the status strobes.
interface lcd_text_driver_if;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    modport master (
        input  char_in,
        output index,
        output lcd_e,
        output lcd_rs,
        output lcd_rw,
        output lcd_data,
        output init_done,
        output frame_done
    );

    modport slave (
        output char_in,
        input  index,
        input  lcd_e,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_data,
        input  init_done,
        input  frame_done
    );
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780 8-bit parallel driver: power-up wait, four-command init, then an endless
// refresh of two 16-character lines fetched one at a time from a registered text source.
module lcd_text_driver #(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SU    = 2,
    parameter int unsigned T_PW    = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_CMD   = 2500,
    parameter int unsigned T_CLR   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_text_driver_if.master bus
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FETCH,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    typedef enum logic [2:0] {
        PH_INIT,
        PH_ADDR1,
        PH_LINE1,
        PH_ADDR2,
        PH_LINE2
    } phase_t;

    localparam logic [19:0] CNT_PWRUP = 20'(T_PWRUP);
    localparam logic [19:0] CNT_SU    = 20'(T_SU);
    localparam logic [19:0] CNT_PW    = 20'(T_PW);
    localparam logic [19:0] CNT_HOLD  = 20'(T_HOLD);
    localparam logic [19:0] CNT_CMD   = 20'(T_CMD);
    localparam logic [19:0] CNT_CLR   = 20'(T_CLR);
    localparam logic [19:0] CNT_FETCH = 20'd2;

    localparam logic [7:0] CMD_ADDR1 = 8'h80;
    localparam logic [7:0] CMD_ADDR2 = 8'hC0;
    localparam logic [4:0] LAST_LINE1 = 5'd15;
    localparam logic [4:0] FIRST_LINE2 = 5'd16;
    localparam logic [4:0] LAST_LINE2 = 5'd31;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [1:0]  init_step_q, init_step_d;
    logic [19:0] cnt_q, cnt_d;
    logic [4:0]  index_q, index_d;
    logic        lcd_e_q, lcd_e_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;

    logic [19:0] limit;
    logic        expired;

    // The single shared counter runs to a per-state limit; only the clear command waits longer.
    always_comb begin
        limit = CNT_CMD;
        case (state_q)
            S_PWRUP: limit = CNT_PWRUP;
            S_FETCH: limit = CNT_FETCH;
            S_SETUP: limit = CNT_SU;
            S_PULSE: limit = CNT_PW;
            S_HOLD:  limit = CNT_HOLD;
            S_WAIT:  limit = (phase_q == PH_INIT && init_step_q == 2'd3) ? CNT_CLR : CNT_CMD;
            default: limit = CNT_CMD;
        endcase
    end

    assign expired = (cnt_q == limit - 20'd1);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        init_step_d  = init_step_q;
        cnt_d        = expired ? 20'd0 : cnt_q + 20'd1;
        index_d      = index_q;
        lcd_e_d      = lcd_e_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;

        if (expired) begin
            case (state_q)
                S_PWRUP: begin
                    state_d    = S_SETUP;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_cmd(init_step_q);
                end
                // Two cycles give the registered source time to answer the new index.
                S_FETCH: begin
                    state_d    = S_SETUP;
                    lcd_rs_d   = 1'b1;
                    lcd_data_d = bus.char_in;
                end
                S_SETUP: begin
                    state_d = S_PULSE;
                    lcd_e_d = 1'b1;
                end
                S_PULSE: begin
                    state_d = S_HOLD;
                    lcd_e_d = 1'b0;
                end
                S_HOLD: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    case (phase_q)
                        PH_INIT: begin
                            state_d  = S_SETUP;
                            lcd_rs_d = 1'b0;
                            if (init_step_q == 2'd3) begin
                                phase_d     = PH_ADDR1;
                                init_done_d = 1'b1;
                                lcd_data_d  = CMD_ADDR1;
                            end else begin
                                init_step_d = init_step_q + 2'd1;
                                lcd_data_d  = init_cmd(init_step_q + 2'd1);
                            end
                        end
                        PH_ADDR1: begin
                            phase_d = PH_LINE1;
                            state_d = S_FETCH;
                            index_d = 5'd0;
                        end
                        PH_LINE1: begin
                            if (index_q == LAST_LINE1) begin
                                phase_d    = PH_ADDR2;
                                state_d    = S_SETUP;
                                lcd_rs_d   = 1'b0;
                                lcd_data_d = CMD_ADDR2;
                            end else begin
                                state_d = S_FETCH;
                                index_d = index_q + 5'd1;
                            end
                        end
                        PH_ADDR2: begin
                            phase_d = PH_LINE2;
                            state_d = S_FETCH;
                            index_d = FIRST_LINE2;
                        end
                        PH_LINE2: begin
                            if (index_q == LAST_LINE2) begin
                                phase_d      = PH_ADDR1;
                                state_d      = S_SETUP;
                                lcd_rs_d     = 1'b0;
                                lcd_data_d   = CMD_ADDR1;
                                frame_done_d = 1'b1;
                            end else begin
                                state_d = S_FETCH;
                                index_d = index_q + 5'd1;
                            end
                        end
                        default: begin
                            phase_d = PH_INIT;
                            state_d = S_PWRUP;
                        end
                    endcase
                end
                default: begin
                    state_d = S_PWRUP;
                    lcd_e_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_PWRUP;
            phase_q      <= PH_INIT;
            init_step_q  <= 2'd0;
            cnt_q        <= 20'd0;
            index_q      <= 5'd0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            init_step_q  <= init_step_d;
            cnt_q        <= cnt_d;
            index_q      <= index_d;
            lcd_e_q      <= lcd_e_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.index      = index_q;
    assign bus.lcd_e      = lcd_e_q;
    assign bus.lcd_rs     = lcd_rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = lcd_data_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with a 1-cycle-latency text source returning 0x41+index;
// monitors log every E pulse, index change and frame_done pulse for later comparison.
module tb_lcd_text_driver;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    lcd_text_driver_if bus();

    lcd_text_driver #(
        .T_PWRUP(10),
        .T_SU   (1),
        .T_PW   (2),
        .T_HOLD (1),
        .T_CMD  (4),
        .T_CLR  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [32];
    logic [7:0] src_q;

    always @(posedge clk) src_q <= mem[bus.index];
    assign bus.char_in = src_q;

    int errors = 0;
    int checks = 0;
    int rel;
    int rel2;
    int base;

    logic       rec_en = 1'b0;
    logic       mon_en = 1'b0;
    logic       e_d1, e_d2, prev_fd;
    logic [8:0] prev_bus;
    logic [4:0] prev_idx = 5'd0;
    int         hi_cnt = 0;
    int         proto_viol = 0;
    int         fd_long = 0;

    logic [8:0] wr_q [$];
    int         wr_cyc [$];
    int         wid_q [$];
    int         fd_cyc [$];
    logic [4:0] idx_q [$];

    // Sampling on the falling edge keeps the monitors clear of the DUT's update edge.
    always @(negedge clk) begin
        e_d1     <= bus.lcd_e;
        e_d2     <= e_d1;
        prev_bus <= {bus.lcd_rs, bus.lcd_data};
        prev_idx <= bus.index;
        prev_fd  <= bus.frame_done;
        hi_cnt   <= bus.lcd_e ? hi_cnt + 1 : 0;
        if (rec_en) begin
            if (bus.lcd_e && !e_d1) begin
                wr_q.push_back({bus.lcd_rs, bus.lcd_data});
                wr_cyc.push_back(cyc);
            end
            if (!bus.lcd_e && e_d1) wid_q.push_back(hi_cnt);
            if (bus.frame_done) fd_cyc.push_back(cyc);
            if (bus.frame_done && prev_fd) fd_long <= fd_long + 1;
            if (bus.index !== prev_idx) idx_q.push_back(bus.index);
        end
        if (mon_en) begin
            proto_viol <= proto_viol
                + ((bus.lcd_rw !== 1'b0) ? 1 : 0)
                + ((({bus.lcd_rs, bus.lcd_data} !== prev_bus) && (bus.lcd_e || e_d1 || e_d2)) ? 1 : 0);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wr_q.size()) return {23'd0, wr_q[i]};
        return 'x;
    endfunction

    function automatic logic [31:0] wcyc_at(input int i);
        if (i < wr_cyc.size()) return wr_cyc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] wid_at(input int i);
        if (i < wid_q.size()) return wid_q[i];
        return 'x;
    endfunction

    function automatic logic [31:0] fd_at(input int i);
        if (i < fd_cyc.size()) return fd_cyc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] idx_at(input int i);
        if (i < idx_q.size()) return {27'd0, idx_q[i]};
        return 'x;
    endfunction

    function automatic logic [7:0] exp_char(input int frame, input int n);
        logic [7:0] v;
        v = 8'(8'h41 + n);
        if (frame == 2 && n == 5) v = 8'h7A;
        return v;
    endfunction

    initial begin
        int b;
        int qi;
        for (int i = 0; i < 32; i++) mem[i] = 8'(8'h41 + i);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check_output("rst_e",          bus.lcd_e,      32'd0);
        check_output("rst_rs",         bus.lcd_rs,     32'd0);
        check_output("rst_rw",         bus.lcd_rw,     32'd0);
        check_output("rst_data",       bus.lcd_data,   32'h00);
        check_output("rst_index",      bus.index,      32'd0);
        check_output("rst_init_done",  bus.init_done,  32'd0);
        check_output("rst_frame_done", bus.frame_done, 32'd0);

        rst = 1'b1;
        rel = cyc;
        rec_en = 1'b1;
        $display("[TB] reset released at cycle %0d", rel);

        wait_to(rel + 10);
        check_output("pwrup_e_low", bus.lcd_e, 32'd0);
        wait_to(rel + 11);
        check_output("first_e_high", bus.lcd_e, 32'd1);
        check_output("first_data",   bus.lcd_data, 32'h38);

        wait_to(rel + 40);
        mon_en = 1'b1;
        wait_to(rel + 45);
        check_output("init_done_before", bus.init_done, 32'd0);
        wait_to(rel + 46);
        check_output("init_done_after", bus.init_done, 32'd1);

        wait_to(rel + 447);
        check_output("idx5_held", bus.index, 32'd5);
        mem[5] = 8'h7A;

        wait_to(rel + 1060);
        mon_en = 1'b0;

        check_output("init_cmd0", wr_at(0), {23'd0, 1'b0, 8'h38});
        check_output("init_cmd1", wr_at(1), {23'd0, 1'b0, 8'h0C});
        check_output("init_cmd2", wr_at(2), {23'd0, 1'b0, 8'h06});
        check_output("init_cmd3", wr_at(3), {23'd0, 1'b0, 8'h01});
        check_output("t_cmd0",  wcyc_at(0), rel + 11);
        check_output("t_cmd1",  wcyc_at(1), rel + 19);
        check_output("t_cmd2",  wcyc_at(2), rel + 27);
        check_output("t_cmd3",  wcyc_at(3), rel + 35);
        check_output("t_addr1", wcyc_at(4), rel + 47);
        check_output("t_char0", wcyc_at(5), rel + 57);
        check_output("t_addr2", wcyc_at(21), rel + 215);
        check_output("t_char16", wcyc_at(22), rel + 225);
        check_output("t_frame2_addr1", wcyc_at(38), rel + 383);
        for (int i = 0; i < 6; i++)
            check_output($sformatf("pulse_width%0d", i), wid_at(i), 32'd2);

        for (int k = 0; k < 3; k++) begin
            b = 4 + 34 * k;
            check_output($sformatf("f%0d_addr1", k), wr_at(b),      {23'd0, 1'b0, 8'h80});
            check_output($sformatf("f%0d_addr2", k), wr_at(b + 17), {23'd0, 1'b0, 8'hC0});
            for (int n = 0; n < 32; n++) begin
                qi = b + ((n < 16) ? 1 + n : 2 + n);
                check_output($sformatf("f%0d_char%0d", k, n), wr_at(qi), {23'd0, 1'b1, exp_char(k, n)});
            end
        end
        check_output("f3_addr1", wr_at(106), {23'd0, 1'b0, 8'h80});

        check_output("fd_count", fd_cyc.size(), 32'd3);
        check_output("fd_first", fd_at(0), rel + 382);
        check_output("fd_second", fd_at(1), rel + 718);
        check_output("fd_third", fd_at(2), rel + 1054);
        check_output("fd_single_cycle", fd_long, 32'd0);

        for (int i = 0; i < 31; i++)
            check_output($sformatf("idx_seq%0d", i), idx_at(i), i + 1);
        check_output("idx_wrap", idx_at(31), 32'd0);
        check_output("idx_after_wrap", idx_at(32), 32'd1);

        check_output("protocol_violations", proto_viol, 32'd0);

        wait_to(rel + 1273);
        check_output("char20_e_high", bus.lcd_e, 32'd1);
        check_output("char20_index",  bus.index, 32'd20);
        rst = 1'b0;
        wait_to(rel + 1274);
        check_output("mid_rst_e",         bus.lcd_e,     32'd0);
        check_output("mid_rst_data",      bus.lcd_data,  32'h00);
        check_output("mid_rst_index",     bus.index,     32'd0);
        check_output("mid_rst_init_done", bus.init_done, 32'd0);
        base = wr_q.size();
        rst = 1'b1;
        rel2 = cyc;

        wait_to(rel2 + 10);
        check_output("restart_pwrup_e_low", bus.lcd_e, 32'd0);
        wait_to(rel2 + 20);
        check_output("restart_cmd0",   wr_at(base),   {23'd0, 1'b0, 8'h38});
        check_output("restart_t_cmd0", wcyc_at(base), rel2 + 11);
        check_output("restart_init_done", bus.init_done, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
